// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and constants for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_RELEASE    = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  localparam int RETRY_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// rtl/reset_seq_timer.sv - up counter with clear and programmable terminal-count flag
module reset_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-domain reset release with hold, timeout and retry
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter  int STAGES         = 4,
  parameter  int HOLD_CYCLES    = 16,
  parameter  int TIMEOUT_CYCLES = 65536,
  localparam int IDX_W          = $clog2(STAGES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_req,
  input  logic [STAGES-1:0]  stage_ready,
  output logic [STAGES-1:0]  stage_rst,
  output logic               all_done,
  output logic               busy,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_stage,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int TW = $clog2(max2(HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STAGES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0]    term;
  logic [TW-1:0]    count;
  logic             tc;
  logic             lost;
  logic             ready_now;
  logic             advance;
  logic             clr;

  // A released stage is exactly a zero bit of stage_rst, so that mask selects the stages to watch.
  assign lost      = |(~stage_rst & ~stage_ready);
  assign ready_now = (state == ST_WAIT_READY) && stage_ready[idx];
  assign term      = (state == ST_WAIT_READY) ? TO_LAST : HOLD_LAST;
  assign advance   = ready_now || (tc && (state != ST_DONE));
  assign clr       = rst_req || lost || advance;

  reset_seq_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .term  (term),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ASSERT;
      idx         <= '0;
      stage_rst   <= '1;
      all_done    <= 1'b0;
      busy        <= 1'b1;
      fault       <= 1'b0;
      fault_stage <= '0;
      retry_count <= '0;
    end else if (rst_req) begin
      state     <= ST_ASSERT;
      idx       <= '0;
      stage_rst <= '1;
      all_done  <= 1'b0;
      busy      <= 1'b1;
      fault     <= 1'b0;
    end else if (lost) begin
      state     <= ST_ASSERT;
      idx       <= '0;
      stage_rst <= '1;
      all_done  <= 1'b0;
      busy      <= 1'b1;
      if (retry_count != '1) retry_count <= retry_count + 1'b1;
    end else begin
      unique case (state)
        ST_ASSERT: begin
          if (tc) begin
            state <= ST_WAIT_READY;
            idx   <= '0;
          end
        end
        ST_WAIT_READY: begin
          // Ready wins over a timeout landing on the same cycle.
          if (stage_ready[idx]) begin
            state          <= ST_RELEASE;
            stage_rst[idx] <= 1'b0;
          end else if (tc) begin
            state       <= ST_ASSERT;
            idx         <= '0;
            stage_rst   <= '1;
            all_done    <= 1'b0;
            busy        <= 1'b1;
            fault       <= 1'b1;
            fault_stage <= idx;
            if (retry_count != '1) retry_count <= retry_count + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (tc) begin
            if (idx == IDX_LAST) begin
              state     <= ST_DONE;
              stage_rst <= '0;
              all_done  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= ST_WAIT_READY;
              idx   <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          all_done <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

  localparam int STAGES = 3;
  localparam int HOLD   = 4;
  localparam int TO     = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req;
  logic [2:0] stage_ready;
  logic [2:0] stage_rst;
  logic       all_done;
  logic       busy;
  logic       fault;
  logic [1:0] fault_stage;
  logic [7:0] retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .STAGES         (STAGES),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rst_req     (rst_req),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .all_done    (all_done),
    .busy        (busy),
    .fault       (fault),
    .fault_stage (fault_stage),
    .retry_count (retry_count)
  );

  // Model: m_rel = number of released stages, m_hold = in a timed hold, m_cnt = cycles in phase.
  int m_rel, m_cnt, m_fs, m_retry;
  bit m_hold, m_fault;

  function automatic void restart();
    m_rel  = 0;
    m_hold = 1;
    m_cnt  = 0;
  endfunction

  function automatic void model_step(input bit r, input bit rq, input logic [2:0] rdy);
    int mask;
    mask = (1 << m_rel) - 1;
    if (r) begin
      restart();
      m_fault = 0; m_fs = 0; m_retry = 0;
    end else if (rq) begin
      restart();
      m_fault = 0;
    end else if ((int'(rdy) & mask) != mask) begin
      if (m_retry < 255) m_retry++;
      restart();
    end else if (m_hold) begin
      if (m_cnt == HOLD - 1) begin
        m_hold = 0;
        m_cnt  = 0;
      end else m_cnt++;
    end else if (m_rel < STAGES) begin
      if (rdy[m_rel]) begin
        m_rel++;
        m_hold = 1;
        m_cnt  = 0;
      end else if (m_cnt == TO - 1) begin
        m_fault = 1;
        m_fs    = m_rel;
        if (m_retry < 255) m_retry++;
        restart();
      end else m_cnt++;
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {stage_rst, all_done, busy, fault, fault_stage, retry_count};
  endfunction

  task automatic cycle(input bit r, input bit rq, input logic [2:0] rdy);
    logic [2:0] e_rst;
    bit         e_done;
    rst = r; rst_req = rq; stage_ready = rdy;
    @(posedge clk);
    model_step(r, rq, rdy);
    @(negedge clk);
    e_rst  = 3'b111 & ~3'((1 << m_rel) - 1);
    e_done = (m_rel == STAGES) && !m_hold;
    chk("model", dut_vec(), {e_rst, e_done, ~e_done, m_fault, 2'(m_fs), 8'(m_retry)});
  endtask

  task automatic run(input int n, input bit rq, input logic [2:0] rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rq, rdy);
  endtask

  task automatic expect_out(input string name, input logic [2:0] e_rst, input logic e_done,
                            input logic e_fault, input logic [1:0] e_fs, input logic [7:0] e_retry);
    chk(name, dut_vec(), {e_rst, e_done, ~e_done, e_fault, e_fs, e_retry});
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 3'b111);
    cycle(1'b1, 1'b0, 3'b111);
  endtask

  typedef struct {
    int         n;
    logic       rq;
    logic [2:0] rdy;
    logic [2:0] e_rst;
    logic       e_done;
    logic       e_fault;
    logic [1:0] e_fs;
    logic [7:0] e_retry;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [2:0] rnd_rdy;
    rst = 1'b1; rst_req = 1'b0; stage_ready = 3'b111;
    m_rel = 0; m_cnt = 0; m_hold = 1; m_fault = 0; m_fs = 0; m_retry = 0;

    // Nominal release followed by a one-cycle lost lock in DONE and full re-sequence.
    tbl.push_back('{4,  1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{1,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{4,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{1,  1'b0, 3'b111, 3'b100, 1'b0, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{5,  1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{3,  1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{1,  1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 2'd0, 8'd0});
    tbl.push_back('{1,  1'b0, 3'b110, 3'b111, 1'b0, 1'b0, 2'd0, 8'd1});
    tbl.push_back('{18, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1});
    tbl.push_back('{1,  1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 2'd0, 8'd1});

    do_reset();
    expect_out("reset", 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].n, tbl[i].rq, tbl[i].rdy);
      expect_out($sformatf("table%0d", i), tbl[i].e_rst, tbl[i].e_done,
                 tbl[i].e_fault, tbl[i].e_fs, tbl[i].e_retry);
    end

    // Late ready on stage 1.
    do_reset();
    expect_out("reset_clears_retry", 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    run(9, 1'b0, 3'b101);  expect_out("late_wait1", 3'b110, 1'b0, 1'b0, 2'd0, 8'd0);
    run(9, 1'b0, 3'b101);  expect_out("late_hold",  3'b110, 1'b0, 1'b0, 2'd0, 8'd0);
    run(1, 1'b0, 3'b111);  expect_out("late_rel1",  3'b100, 1'b0, 1'b0, 2'd0, 8'd0);
    run(5, 1'b0, 3'b111);  expect_out("late_rel2",  3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
    run(4, 1'b0, 3'b111);  expect_out("late_done",  3'b000, 1'b1, 1'b0, 2'd0, 8'd0);

    // Timeout on stage 2, retry, rst_req with a readiness drop, soft reset in RELEASE.
    do_reset();
    run(14, 1'b0, 3'b011); expect_out("to_wait2",   3'b100, 1'b0, 1'b0, 2'd0, 8'd0);
    run(31, 1'b0, 3'b011); expect_out("to_edge",    3'b100, 1'b0, 1'b0, 2'd0, 8'd0);
    run(1, 1'b0, 3'b011);  expect_out("to_fault",   3'b111, 1'b0, 1'b1, 2'd2, 8'd1);
    run(19, 1'b0, 3'b111); expect_out("to_recover", 3'b000, 1'b1, 1'b1, 2'd2, 8'd1);
    cycle(1'b0, 1'b1, 3'b110);
    expect_out("rq_and_drop", 3'b111, 1'b0, 1'b0, 2'd2, 8'd1);
    run(46, 1'b0, 3'b011); expect_out("to_again",   3'b111, 1'b0, 1'b1, 2'd2, 8'd2);
    run(11, 1'b0, 3'b111); expect_out("rel1_fault", 3'b100, 1'b0, 1'b1, 2'd2, 8'd2);
    cycle(1'b0, 1'b1, 3'b111);
    expect_out("soft_rst",    3'b111, 1'b0, 1'b0, 2'd2, 8'd2);
    run(4, 1'b0, 3'b111);  expect_out("soft_assert", 3'b111, 1'b0, 1'b0, 2'd2, 8'd2);
    run(1, 1'b0, 3'b111);  expect_out("soft_rel0",   3'b110, 1'b0, 1'b0, 2'd2, 8'd2);

    // Ready arriving on the exact timeout cycle.
    do_reset();
    run(45, 1'b0, 3'b011); expect_out("simul_wait", 3'b100, 1'b0, 1'b0, 2'd0, 8'd0);
    run(1, 1'b0, 3'b111);  expect_out("simul_rel",  3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
    run(4, 1'b0, 3'b111);  expect_out("simul_done", 3'b000, 1'b1, 1'b0, 2'd0, 8'd0);

    // retry_count saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      run(6, 1'b0, 3'b111);
      run(1, 1'b0, 3'b110);
    end
    expect_out("retry_sat", 3'b111, 1'b0, 1'b0, 2'd0, 8'd255);

    // Random stimulus against the model.
    do_reset();
    rnd_rdy = 3'b111;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 59) == 0) rnd_rdy[b] = ~rnd_rdy[b];
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0, rnd_rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
